// File: rtl/ei_extrema_store_if.sv
`default_nettype none
// ============================================================================
// Module      : ei_extrema_store_if
// Description : Extremum-trigger capture and read-handshake bundle for the
//               EMD extrema store.
// Revision    : 1.0 - initial release
// ============================================================================
interface ei_extrema_store_if #(
    parameter int AW = 4
);
    logic          Trg;
    logic [15:0]   Time;
    logic [15:0]   B;
    logic          Rd_en;
    logic          Clr_ovf;
    logic          Rd_valid;
    logic [15:0]   Rd_time;
    logic [15:0]   Rd_val;
    logic [AW:0]   Count;
    logic          Empty;
    logic          Full;
    logic          Ovf;
    logic [15:0]   Interval;
    logic          Int_valid;

    modport master (
        output Trg, Time, B, Rd_en, Clr_ovf,
        input  Rd_valid, Rd_time, Rd_val, Count, Empty, Full, Ovf, Interval, Int_valid
    );

    modport slave (
        input  Trg, Time, B, Rd_en, Clr_ovf,
        output Rd_valid, Rd_time, Rd_val, Count, Empty, Full, Ovf, Interval, Int_valid
    );
endinterface
`default_nettype wire

// File: rtl/ei_extrema_store.sv
`default_nettype none
// ============================================================================
// Module      : ei_extrema_store
// Description : Captures {Time,B} on each extremum trigger into a FIFO, drains
//               it through a registered read, tracks extremum spacing/overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module ei_extrema_store #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DEDUP = 1
) (
    input  wire logic            CLK,
    input  wire logic            RST,
    ei_extrema_store_if.slave    bus
);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          ovf_q, ovf_d;
    logic          rd_valid_q, rd_valid_d;
    logic [15:0]   rd_time_q, rd_time_d;
    logic [15:0]   rd_val_q, rd_val_d;
    logic [15:0]   interval_q, interval_d;
    logic          int_valid_q, int_valid_d;
    logic [15:0]   last_time_q, last_time_d;
    logic          have_last_q, have_last_d;

    logic w_dup, w_capture, w_pop, w_push, w_drop;

    assign w_dup     = (DEDUP != 0) && have_last_q && (bus.Time == last_time_q);
    assign w_capture = bus.Trg && !w_dup;
    assign w_pop     = bus.Rd_en && !empty_q;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the write.
    assign w_push    = w_capture && (!full_q || w_pop);
    assign w_drop    = w_capture && full_q && !w_pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        rd_valid_d  = 1'b0;
        rd_time_d   = rd_time_q;
        rd_val_d    = rd_val_q;
        interval_d  = interval_q;
        int_valid_d = int_valid_q;
        last_time_d = last_time_q;
        have_last_d = have_last_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            rd_valid_d = 1'b1;
            rd_time_d  = mem_q[rd_ptr_q][31:16];
            rd_val_d   = mem_q[rd_ptr_q][15:0];
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end

        if (bus.Clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (w_drop) begin
            ovf_d = 1'b1;
        end

        // Spacing tracks every accepted trigger, even one lost to a full FIFO.
        if (w_capture) begin
            interval_d  = bus.Time - last_time_q;
            last_time_d = bus.Time;
            int_valid_d = have_last_q;
            have_last_d = 1'b1;
        end
    end

    assign empty_d = (count_d == '0);
    assign full_d  = (count_d == c_DEPTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_time_q   <= '0;
            rd_val_q    <= '0;
            interval_q  <= '0;
            int_valid_q <= 1'b0;
            last_time_q <= '0;
            have_last_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            rd_valid_q  <= rd_valid_d;
            rd_time_q   <= rd_time_d;
            rd_val_q    <= rd_val_d;
            interval_q  <= interval_d;
            int_valid_q <= int_valid_d;
            last_time_q <= last_time_d;
            have_last_q <= have_last_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST && w_push) begin
            mem_q[wr_ptr_q] <= {bus.Time, bus.B};
        end
    end

    assign bus.Rd_valid  = rd_valid_q;
    assign bus.Rd_time   = rd_time_q;
    assign bus.Rd_val    = rd_val_q;
    assign bus.Count     = count_q;
    assign bus.Empty     = empty_q;
    assign bus.Full      = full_q;
    assign bus.Ovf       = ovf_q;
    assign bus.Interval  = interval_q;
    assign bus.Int_valid = int_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_ei_extrema_store.sv
`default_nettype none
// ============================================================================
// Module      : tb_ei_extrema_store
// Description : Directed self-checking bench for ei_extrema_store.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ei_extrema_store;
    logic CLK;
    logic RST;
    int   n_checks;
    int   n_fail;

    ei_extrema_store_if #(.AW(4)) bus ();

    ei_extrema_store #(.DEPTH(16), .AW(4), .DEDUP(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.Trg     = 1'b0;
        bus.Time    = '0;
        bus.B       = '0;
        bus.Rd_en   = 1'b0;
        bus.Clr_ovf = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        idle_inputs();
        step();
        step();
        RST = 1'b0;
        n_checks++;
        if (bus.Count !== 5'd0 || bus.Empty !== 1'b1 || bus.Full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fifo: count=%0d empty=%b full=%b, need 0/1/0", bus.Count, bus.Empty, bus.Full);
        end
        n_checks++;
        if (bus.Ovf !== 1'b0 || bus.Rd_valid !== 1'b0 || bus.Rd_time !== 16'd0 || bus.Rd_val !== 16'd0
            || bus.Interval !== 16'd0 || bus.Int_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: ovf=%b rv=%b rt=%0d rval=%0d int=%0d iv=%b, need all 0",
                     bus.Ovf, bus.Rd_valid, bus.Rd_time, bus.Rd_val, bus.Interval, bus.Int_valid);
        end
    endtask

    task automatic test_basic();
        logic [15:0] times [3];
        logic [15:0] vals  [3];
        times[0] = 16'd3;  vals[0] = 16'd10;
        times[1] = 16'd40; vals[1] = 16'hFFF9;
        times[2] = 16'd95; vals[2] = 16'd22;
        for (int i = 0; i < 3; i++) begin
            bus.Trg = 1'b1; bus.Time = times[i]; bus.B = vals[i];
            step();
            bus.Trg = 1'b0;
            step();
        end
        n_checks++;
        if (bus.Count !== 5'd3 || bus.Empty !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_count: count=%0d empty=%b, need 3/0", bus.Count, bus.Empty);
        end
        n_checks++;
        if (bus.Interval !== 16'd55 || bus.Int_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_interval: int=%0d iv=%b, need 55/1", bus.Interval, bus.Int_valid);
        end
        for (int i = 0; i < 3; i++) begin
            bus.Rd_en = 1'b1;
            step();
            bus.Rd_en = 1'b0;
            n_checks++;
            if (bus.Rd_valid !== 1'b1 || bus.Rd_time !== times[i] || bus.Rd_val !== vals[i]) begin
                n_fail++;
                $display("FAIL basic_read%0d: rv=%b time=%0d val=%h, need 1/%0d/%h",
                         i, bus.Rd_valid, bus.Rd_time, bus.Rd_val, times[i], vals[i]);
            end
            step();
            n_checks++;
            if (bus.Rd_valid !== 1'b0 || bus.Rd_time !== times[i]) begin
                n_fail++;
                $display("FAIL basic_hold%0d: rv=%b time=%0d, need 0/%0d", i, bus.Rd_valid, bus.Rd_time, times[i]);
            end
        end
        n_checks++;
        if (bus.Count !== 5'd0 || bus.Empty !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_drained: count=%0d empty=%b, need 0/1", bus.Count, bus.Empty);
        end
    endtask

    task automatic test_dedup();
        bus.Trg = 1'b1; bus.Time = 16'd50; bus.B = 16'd7;
        step();
        // 50 - 95 modulo 2^16
        n_checks++;
        if (bus.Count !== 5'd1 || bus.Interval !== 16'd65491) begin
            n_fail++;
            $display("FAIL dedup_first: count=%0d int=%0d, need 1/65491", bus.Count, bus.Interval);
        end
        step(); step(); step();
        bus.Trg = 1'b0;
        n_checks++;
        if (bus.Count !== 5'd1 || bus.Interval !== 16'd65491) begin
            n_fail++;
            $display("FAIL dedup_held: count=%0d int=%0d, need 1/65491", bus.Count, bus.Interval);
        end
        bus.Rd_en = 1'b1;
        step();
        bus.Rd_en = 1'b0;
        n_checks++;
        if (bus.Rd_valid !== 1'b1 || bus.Rd_time !== 16'd50 || bus.Rd_val !== 16'd7 || bus.Empty !== 1'b1) begin
            n_fail++;
            $display("FAIL dedup_read: rv=%b time=%0d val=%0d empty=%b, need 1/50/7/1",
                     bus.Rd_valid, bus.Rd_time, bus.Rd_val, bus.Empty);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            bus.Trg = 1'b1; bus.Time = 16'(100 + i); bus.B = 16'(i);
            step();
        end
        n_checks++;
        if (bus.Full !== 1'b1 || bus.Count !== 5'd16 || bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fill: full=%b count=%0d ovf=%b, need 1/16/0", bus.Full, bus.Count, bus.Ovf);
        end
        bus.Time = 16'd116; bus.B = 16'd16;
        step();
        bus.Trg = 1'b0;
        n_checks++;
        if (bus.Full !== 1'b1 || bus.Count !== 5'd16 || bus.Ovf !== 1'b1 || bus.Interval !== 16'd1) begin
            n_fail++;
            $display("FAIL ovf_drop: full=%b count=%0d ovf=%b int=%0d, need 1/16/1/1",
                     bus.Full, bus.Count, bus.Ovf, bus.Interval);
        end
        bus.Clr_ovf = 1'b1;
        step();
        n_checks++;
        if (bus.Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b, need 0", bus.Ovf);
        end
        bus.Trg = 1'b1; bus.Time = 16'd117; bus.B = 16'd17;
        step();
        bus.Trg = 1'b0;
        n_checks++;
        if (bus.Ovf !== 1'b1 || bus.Count !== 5'd16) begin
            n_fail++;
            $display("FAIL ovf_set_wins: ovf=%b count=%0d, need 1/16", bus.Ovf, bus.Count);
        end
        step();
        bus.Clr_ovf = 1'b0;
    endtask

    task automatic test_full_simultaneous();
        logic [15:0] exp_t;
        bus.Trg = 1'b1; bus.Time = 16'd200; bus.B = 16'hFFFF; bus.Rd_en = 1'b1;
        step();
        bus.Trg = 1'b0; bus.Rd_en = 1'b0;
        n_checks++;
        if (bus.Count !== 5'd16 || bus.Full !== 1'b1 || bus.Ovf !== 1'b0
            || bus.Rd_valid !== 1'b1 || bus.Rd_time !== 16'd100) begin
            n_fail++;
            $display("FAIL full_simul: count=%0d full=%b ovf=%b rv=%b time=%0d, need 16/1/0/1/100",
                     bus.Count, bus.Full, bus.Ovf, bus.Rd_valid, bus.Rd_time);
        end
        bus.Rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            exp_t = (i < 15) ? 16'(101 + i) : 16'd200;
            n_checks++;
            if (bus.Rd_valid !== 1'b1 || bus.Rd_time !== exp_t) begin
                n_fail++;
                $display("FAIL drain%0d: rv=%b time=%0d, need 1/%0d", i, bus.Rd_valid, bus.Rd_time, exp_t);
            end
        end
        bus.Rd_en = 1'b0;
        n_checks++;
        if (bus.Rd_val !== 16'hFFFF || bus.Empty !== 1'b1 || bus.Count !== 5'd0) begin
            n_fail++;
            $display("FAIL drain_end: val=%h empty=%b count=%0d, need ffff/1/0", bus.Rd_val, bus.Empty, bus.Count);
        end
    endtask

    task automatic test_wrap_empty();
        bus.Trg = 1'b1; bus.Time = 16'd65530; bus.B = 16'd1;
        step();
        bus.Time = 16'd4; bus.B = 16'd2;
        step();
        bus.Trg = 1'b0;
        n_checks++;
        if (bus.Interval !== 16'd10 || bus.Int_valid !== 1'b1 || bus.Count !== 5'd2) begin
            n_fail++;
            $display("FAIL wrap_interval: int=%0d iv=%b count=%0d, need 10/1/2", bus.Interval, bus.Int_valid, bus.Count);
        end
        bus.Rd_en = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.Rd_valid !== 1'b1 || bus.Rd_time !== 16'd4 || bus.Empty !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_read: rv=%b time=%0d empty=%b, need 1/4/1", bus.Rd_valid, bus.Rd_time, bus.Empty);
        end
        step();
        bus.Rd_en = 1'b0;
        n_checks++;
        if (bus.Rd_valid !== 1'b0 || bus.Count !== 5'd0 || bus.Rd_time !== 16'd4 || bus.Empty !== 1'b1) begin
            n_fail++;
            $display("FAIL empty_read: rv=%b count=%0d time=%0d empty=%b, need 0/0/4/1",
                     bus.Rd_valid, bus.Count, bus.Rd_time, bus.Empty);
        end
    endtask

    task automatic test_reset_midway();
        for (int i = 1; i <= 5; i++) begin
            bus.Trg = 1'b1; bus.Time = 16'(i * 10); bus.B = 16'(i);
            step();
        end
        n_checks++;
        if (bus.Count !== 5'd5) begin
            n_fail++;
            $display("FAIL mid_fill: count=%0d, need 5", bus.Count);
        end
        RST = 1'b1; bus.Rd_en = 1'b1; bus.Time = 16'd99;
        step();
        RST = 1'b0;
        idle_inputs();
        n_checks++;
        if (bus.Count !== 5'd0 || bus.Empty !== 1'b1 || bus.Rd_valid !== 1'b0 || bus.Int_valid !== 1'b0
            || bus.Interval !== 16'd0 || bus.Rd_time !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset: count=%0d empty=%b rv=%b iv=%b int=%0d rt=%0d, need 0/1/0/0/0/0",
                     bus.Count, bus.Empty, bus.Rd_valid, bus.Int_valid, bus.Interval, bus.Rd_time);
        end
        // A post-reset read must find nothing: entries were discarded.
        bus.Rd_en = 1'b1;
        step();
        bus.Rd_en = 1'b0;
        n_checks++;
        if (bus.Rd_valid !== 1'b0 || bus.Count !== 5'd0) begin
            n_fail++;
            $display("FAIL mid_after: rv=%b count=%0d, need 0/0", bus.Rd_valid, bus.Count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_basic();
        test_dedup();
        test_overflow();
        test_full_simultaneous();
        test_wrap_empty();
        test_reset_midway();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ei_extrema_store.md
Name: ei_extrema_store

Overview:
- Consumer end of the extremum-trigger interface of the EMD extrema path.
- Captures the Time stamp and centre sample (B) whenever the extremum detector asserts Trg, and buffers them in a FIFO.
- The envelope/interpolation stage drains the FIFO through a registered read handshake.
- Also reports the spacing between successive extrema and overflow status.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- AW, 4, address width; must equal log2(DEPTH).
- DEDUP, 1, when 1 drop a trigger whose Time equals the last captured Time.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous reset, active-high.
- Trg  in  1  extremum trigger from detector, sampled on rising CLK.
- Time  in  16  unsigned sample index accompanying Trg.
- B  in  16  signed centre sample value accompanying Trg.
- Rd_en  in  1  read request from downstream.
- Rd_valid  out  1  one-cycle pulse; Rd_time/Rd_val valid.
- Rd_time  out  16  stored Time of popped entry.
- Rd_val  out  16  stored signed B of popped entry.
- Count  out  AW+1  entries currently held, 0..DEPTH.
- Empty  out  1  Count==0.
- Full  out  1  Count==DEPTH.
- Ovf  out  1  sticky: a trigger was dropped because FIFO was full.
- Clr_ovf  in  1  clears Ovf.
- Interval  out  16  Time difference between the last two captured extrema.
- Int_valid  out  1  high once at least two extrema have been captured since reset.

Behaviour:
- Reset (RST=1 at rising edge): wr/rd pointers=0, Count=0, Empty=1, Full=0, Ovf=0, Rd_valid=0, Rd_time=0, Rd_val=0, Interval=0, Int_valid=0, last-time register=0, have_last=0. Reset mid-operation discards all stored entries; RST overrides every other input that cycle.
- Capture: a capture event exists when Trg=1 at a rising edge, and not (DEDUP=1 and have_last=1 and Time==last_time).
- Write on capture event and not Full (see simultaneous rule): store {Time,B} at wr_ptr, wr_ptr+1 (wraps modulo DEPTH). Entry is readable the next cycle.
- Capture when Full and no pop that cycle: entry dropped, Ovf<=1, pointers unchanged.
- Interval/last_time update on every capture event, including ones dropped for Full:
  - Interval <= Time - last_time, 16-bit unsigned modulo subtraction, so a Time wrap 65535->2 gives 3.
  - last_time <= Time.
  - Int_valid <= have_last; have_last <= 1.
- Read on Rd_en=1 and not Empty: Rd_time/Rd_val <= entry at rd_ptr; Rd_valid=1 in the next cycle (latency 1); rd_ptr+1 with wrap.
- Rd_en while Empty: ignored, Rd_valid=0, no error.
- Rd_valid is 0 in any cycle not following a successful pop. Rd_time/Rd_val hold their last value otherwise.
- Simultaneous write and read:
  - Both occur, Count unchanged.
  - When Full, the pop frees the slot in the same cycle, so the write is accepted and Ovf is not set.
  - When Empty, the write completes and the read is ignored; the new entry is not bypassed.
- Count is +1 on write only, -1 on read only, unchanged otherwise. Empty/Full are registered and consistent with Count every cycle.
- Ovf: Clr_ovf=1 clears it. If Clr_ovf and a new overflow occur in the same cycle, Ovf ends at 1 (set wins).
- No combinational path from any input to any output.

Test Plan:
- Reset, then Trg pulses at Time=3 (B=10), Time=40 (B=-7), Time=95 (B=22); Rd_en pulsed three times -> Rd_valid one cycle after each; outputs (3,10), (40,-7), (95,22) in order; Count 3->0; Interval=55, Int_valid=1.
- DEDUP=1: Trg held high 4 cycles with Time=50 -> exactly one entry stored, Count=1, Interval unchanged after the first cycle.
- DEPTH=16: 17 distinct captures with no reads -> Full=1, Count=16, Ovf=1, the 17th entry absent on drain. Clr_ovf=1 -> Ovf=0.
- Full FIFO plus simultaneous Trg and Rd_en -> Count stays 16, Ovf stays 0, the new entry is read last.
- Time wrap: captures at 65530 then 4 -> Interval=10. Rd_en on an empty FIFO -> Rd_valid=0, Count=0.
- RST asserted with 5 entries stored and Rd_en=1 the same cycle -> next cycle Count=0, Empty=1, Rd_valid=0, Int_valid=0.
